// File: rtl/accel_pkg.sv
// Shared constants, frame-length helper and FSM encoding for the accelerometer frame packer.
package accel_pkg;

    localparam logic [7:0] C_SYNC_DEFAULT = 8'hA5;
    localparam int         C_DATA_BYTES   = 6;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SEND,
        ST_WAIT
    } state_t;

    // Sync byte + data bytes, plus one checksum byte when enabled.
    function automatic int frame_len(input bit csum_en);
        return csum_en ? C_DATA_BYTES + 2 : C_DATA_BYTES + 1;
    endfunction

endpackage

// File: rtl/sample_fifo.sv
// Synchronous FIFO with occupancy count; pushes while full and pops while empty are ignored.
module sample_fifo #(
    parameter int p_width = 48,
    parameter int p_depth = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [p_width-1:0]       din_i,
    output logic [p_width-1:0]       dout_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(p_depth):0] level_o
);

    localparam int C_AW = $clog2(p_depth);
    localparam int C_LW = C_AW + 1;

    logic [p_width-1:0] r_mem [p_depth];
    logic [C_AW-1:0]    r_wr_ptr;
    logic [C_AW-1:0]    r_rd_ptr;
    logic [C_LW-1:0]    r_level;
    logic               w_do_push;
    logic               w_do_pop;

    assign full_o    = (r_level == C_LW'(p_depth));
    assign empty_o   = (r_level == '0);
    assign level_o   = r_level;
    assign dout_o    = r_mem[r_rd_ptr];
    assign w_do_push = push_i && !full_o;
    assign w_do_pop  = pop_i && !empty_o;

    always_ff @(posedge clk_i) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= din_i;
        end
    end

    // Power-of-two depth lets the pointers wrap without compare logic.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + C_AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + C_AW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_level <= r_level + C_LW'(1);
                2'b01:   r_level <= r_level - C_LW'(1);
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/accel_frame_packer.sv
// Buffers 3-axis samples and serialises each as a sync/data/checksum byte frame
// over the uart_tx start/done handshake.
module accel_frame_packer
    import accel_pkg::*;
#(
    parameter int         p_depth   = 4,
    parameter logic [7:0] p_sync    = C_SYNC_DEFAULT,
    parameter bit         p_csum_en = 1'b1
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [15:0]              ax_i,
    input  logic [15:0]              ay_i,
    input  logic [15:0]              az_i,
    input  logic                     valid_i,
    output logic [7:0]               din_o,
    output logic                     tx_start_o,
    input  logic                     tx_done_tick_i,
    output logic                     busy_o,
    output logic [$clog2(p_depth):0] level_o,
    output logic                     overflow_o,
    output logic [7:0]               drop_cnt_o
);

    localparam int         C_LW   = $clog2(p_depth) + 1;
    localparam logic [2:0] C_LAST = 3'(frame_len(p_csum_en) - 1);

    state_t          r_state;
    state_t          w_next;
    logic [47:0]     r_shift;
    logic [7:0]      r_csum;
    logic [2:0]      r_idx;
    logic            r_overflow;
    logic [7:0]      r_drop_cnt;
    logic [47:0]     w_head;
    logic [C_LW-1:0] w_level;
    logic            w_full;
    logic            w_empty;
    logic            w_push;
    logic            w_pop;
    logic            w_drop;
    logic            w_csum_byte;
    logic            w_data_byte;
    logic            w_last;
    logic            w_tick;
    logic [7:0]      w_byte;

    assign w_push      = valid_i && !w_full;
    assign w_drop      = valid_i && w_full;
    assign w_csum_byte = p_csum_en && (r_idx == 3'd7);
    assign w_data_byte = (r_idx != 3'd0) && !w_csum_byte;
    assign w_last      = (r_idx == C_LAST);
    assign w_tick      = (r_state == ST_WAIT) && tx_done_tick_i;

    sample_fifo #(
        .p_width(48),
        .p_depth(p_depth)
    ) u_fifo (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .push_i (w_push),
        .pop_i  (w_pop),
        .din_i  ({ax_i, ay_i, az_i}),
        .dout_o (w_head),
        .full_o (w_full),
        .empty_o(w_empty),
        .level_o(w_level)
    );

    always_comb begin
        w_byte = r_shift[47:40];
        if (r_idx == 3'd0) begin
            w_byte = p_sync;
        end else if (w_csum_byte) begin
            w_byte = r_csum;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (!w_empty) w_next = ST_LOAD;
            ST_LOAD: w_next = ST_SEND;
            ST_SEND: w_next = ST_WAIT;
            ST_WAIT: begin
                if (tx_done_tick_i) begin
                    if (!w_last) begin
                        w_next = ST_SEND;
                    end else if (!w_empty) begin
                        w_next = ST_LOAD;
                    end else begin
                        w_next = ST_IDLE;
                    end
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // din_o is forced to zero outside SEND/WAIT so reset leaves it clean.
    always_comb begin
        tx_start_o = 1'b0;
        w_pop      = 1'b0;
        din_o      = 8'h00;
        case (r_state)
            ST_LOAD: w_pop = 1'b1;
            ST_SEND: begin
                tx_start_o = 1'b1;
                din_o      = w_byte;
            end
            ST_WAIT: din_o = w_byte;
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_idx      <= 3'd0;
            r_overflow <= 1'b0;
            r_drop_cnt <= 8'd0;
        end else begin
            r_overflow <= w_drop;
            if (w_drop && (r_drop_cnt != 8'hFF)) begin
                r_drop_cnt <= r_drop_cnt + 8'd1;
            end
            if (r_state == ST_LOAD) begin
                r_idx <= 3'd0;
            end else if (w_tick) begin
                r_idx <= r_idx + 3'd1;
            end
        end
    end

    // Data bytes leave from the top of the shift register and fold into the checksum.
    always_ff @(posedge clk_i) begin
        if (r_state == ST_LOAD) begin
            r_shift <= w_head;
            r_csum  <= 8'h00;
        end else if (w_tick && w_data_byte) begin
            r_shift <= {r_shift[39:0], 8'h00};
            r_csum  <= r_csum ^ w_byte;
        end
    end

    assign busy_o     = (r_state != ST_IDLE) || !w_empty;
    assign level_o    = w_level;
    assign overflow_o = r_overflow;
    assign drop_cnt_o = r_drop_cnt;

endmodule

// File: doc/accel_frame_packer.md
Name: accel_frame_packer

Overview:
Downstream stage of the ADXL362 reader and upstream of the UART transmitter. It buffers 3-axis samples, each 16 bits per axis, in a small FIFO. It serialises each sample into a framed byte stream: sync byte, six data bytes, then an XOR checksum. Bytes go to uart_tx one at a time over the existing tx_start / tx_done_tick handshake. Samples that arrive while a frame is in flight are no longer lost, and the host can resynchronise on the sync byte.

Parameters:
p_depth, 4, sample FIFO depth in samples; power of 2, minimum 2.
p_sync, 8'hA5, frame sync byte.
p_csum_en, 1, 1 = append XOR checksum byte (8-byte frame); 0 = 7-byte frame.

Ports:
clk_i  in  1  system clock
rst_i  in  1  asynchronous active-high reset
ax_i  in  16  X-axis sample
ay_i  in  16  Y-axis sample
az_i  in  16  Z-axis sample
valid_i  in  1  one-cycle strobe; ax/ay/az are valid in that cycle (driven by ADXL362 ready_o)
din_o  out  8  byte to uart_tx din_i
tx_start_o  out  1  one-cycle start strobe to uart_tx
tx_done_tick_i  in  1  uart_tx byte-complete tick
busy_o  out  1  high while a frame is being sent or the FIFO is non-empty
level_o  out  clog2(p_depth)+1  FIFO occupancy
overflow_o  out  1  one-cycle pulse when a sample is dropped
drop_cnt_o  out  8  saturating count of dropped samples

Behaviour:
- Clock and reset: one clock, clk_i; reset rst_i is asynchronous and active-high.
- Reset values: din_o=0, tx_start_o=0, busy_o=0, level_o=0, overflow_o=0, drop_cnt_o=0. FIFO is emptied and the FSM goes to IDLE.
- Reset mid-frame: the partial frame is abandoned. There is no resume after reset release.
- Push:
  - valid_i with level < p_depth: {ax,ay,az} is written at that clock edge and level increments.
  - valid_i with level == p_depth: the sample is dropped, even if a pop happens in the same cycle.
  - On a drop, overflow_o pulses the next cycle and drop_cnt_o increments, saturating at 255.
- Simultaneous push and pop (not full): both happen and level is unchanged.
- FSM states: IDLE, LOAD, SEND, WAIT.
  - IDLE -> LOAD when level != 0.
  - LOAD: pops the head into a 48-bit shift register, clears the checksum, sets byte index = 0. Goes to SEND next cycle.
  - SEND: drives din_o with the current byte, asserts tx_start_o for exactly this one cycle, then goes to WAIT.
  - WAIT: holds din_o stable. On tx_done_tick_i it advances the byte index. If the frame is not finished it goes to SEND; if finished it goes to IDLE, or directly to LOAD if level != 0 (back-to-back frames).
- Byte order:
  - idx0 = p_sync
  - idx1..6 = ax[15:8], ax[7:0], ay[15:8], ay[7:0], az[15:8], az[7:0]
  - idx7 = XOR of idx1..6, present only when p_csum_en = 1
- Checksum: accumulated as data bytes are sent. The sync byte is excluded.
- Latency: with the FSM in IDLE and the FIFO empty, valid_i in cycle N gives tx_start_o high in cycle N+3. Sequence: written at N, IDLE sees level at N+1, LOAD at N+2, SEND at N+3.
- tx_done_tick_i outside WAIT is ignored.
- tx_start_o is never high in two consecutive cycles.
- busy_o = (state != IDLE) || (level != 0).

Decomposition:
- Shared package accel_pkg holds:
  - constants C_SYNC_DEFAULT = 8'hA5, C_DATA_BYTES = 6;
  - a frame-length function of p_csum_en;
  - the FSM state encoding.
- One sub-module, sample_fifo: synchronous FIFO with width and depth parameters and the async active-high reset. It provides push, pop, full, empty and level, with drop-on-full handled in the parent.
- Byte mux, checksum and FSM stay in accel_frame_packer.

Test Plan:
- Single frame, p_csum_en=1: ax=16'h1234, ay=16'hABCD, az=16'h00FF, with uart model tick 10 cycles after each start -> din_o sequence A5 12 34 AB CD 00 FF BF. Exactly 8 tx_start_o pulses, first at valid cycle+3; busy_o drops after the last tick.
- p_csum_en=0 with the same sample -> 7 bytes ending at FF; no 8th tx_start_o.
- Burst of 6 valid_i strobes 2 cycles apart during a slow UART (tick 100 cycles after start), p_depth=4 -> first sample goes straight to the shift register and is sent. Level peaks at 4, sample 6 is dropped, overflow_o pulses once, drop_cnt_o=1. The 5 accepted frames are sent back-to-back in order.
- Reset asserted in WAIT mid-frame (after byte 3) -> all outputs at reset values immediately. After release with no valid_i, no tx_start_o occurs.
- Spurious tx_done_tick_i pulses in IDLE and in SEND -> no byte index change and no extra tx_start_o; frame content unchanged.
- 300 drops with the FIFO held full (slow UART) -> drop_cnt_o saturates at 255; overflow_o still pulses per drop.
